// File: rtl/md_scheduler_if.sv
// Decode, writeback and mul/div unit signals seen by the mul/div scheduler.
// master = pipeline/unit side, slave = scheduler.
interface md_scheduler_if;
  logic        dec_valid;
  logic        dec_is_md;
  logic        dec_is_div;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_uses_rs1;
  logic        dec_uses_rs2;
  logic        dec_writes_rd;
  logic        wb_pipe_we;
  logic        md_result_ready;
  logic [31:0] md_result;
  logic        md_exception;
  logic        stall_decode;
  logic        md_start;
  logic        md_op;
  logic        md_busy;
  logic        rf_we_md;
  logic [4:0]  rf_rd_md;
  logic [31:0] rf_wd_md;

  modport master (
    output dec_valid, dec_is_md, dec_is_div,
    output dec_rs1, dec_rs2, dec_rd,
    output dec_uses_rs1, dec_uses_rs2, dec_writes_rd,
    output wb_pipe_we,
    output md_result_ready, md_result, md_exception,
    input  stall_decode, md_start, md_op, md_busy,
    input  rf_we_md, rf_rd_md, rf_wd_md
  );

  modport slave (
    input  dec_valid, dec_is_md, dec_is_div,
    input  dec_rs1, dec_rs2, dec_rd,
    input  dec_uses_rs1, dec_uses_rs2, dec_writes_rd,
    input  wb_pipe_we,
    input  md_result_ready, md_result, md_exception,
    output stall_decode, md_start, md_op, md_busy,
    output rf_we_md, rf_rd_md, rf_wd_md
  );
endinterface

// File: rtl/md_scheduler.sv
// Mul/div sequencing and interlock controller: issue, watchdog,
// pending-rd hazards and register-file write port arbitration.
module md_scheduler #(
  parameter int MAX_CYCLES   = 40,
  parameter int MUL_EXC_CODE = 1,
  parameter int DIV_EXC_CODE = 2,
  parameter int TIMEOUT_CODE = 3
) (
  input  logic           clock,
  input  logic           reset,
  md_scheduler_if.slave  bus
);
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [4:0] EXC_RD = 5'd30;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count;
  logic [4:0]    pend_rd, hold_rd;
  logic [31:0]   hold_wd;
  logic          op_q, start_q;
  logic          busy, timeout, done, accept, active, we;
  logic [4:0]    fin_rd, wr_rd;
  logic [31:0]   fin_wd, wr_wd;

  function automatic logic hit(input logic [4:0] r,
                               input logic [4:0] p);
    return (r != 5'd0) && ((r == p) || (r == EXC_RD));
  endfunction

  always_comb begin
    busy    = (state != IDLE);
    timeout = (state == BUSY) && !bus.md_result_ready
              && (count == CW'(MAX_CYCLES - 1));
    done    = (state == BUSY)
              && (bus.md_result_ready || timeout);
    fin_rd  = pend_rd;
    fin_wd  = bus.md_result;
    if (timeout) begin
      fin_rd = EXC_RD;
      fin_wd = 32'(TIMEOUT_CODE);
    end else if (bus.md_exception) begin
      fin_rd = EXC_RD;
      fin_wd = op_q ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
    end
    active = 1'b0;
    wr_rd  = 5'd0;
    wr_wd  = 32'd0;
    if (!bus.wb_pipe_we && done) begin
      active = 1'b1;
      wr_rd  = fin_rd;
      wr_wd  = fin_wd;
    end else if (!bus.wb_pipe_we && state == HOLD) begin
      active = 1'b1;
      wr_rd  = hold_rd;
      wr_wd  = hold_wd;
    end
    // a result aimed at x0 is consumed without touching the port
    we = active && (wr_rd != 5'd0);
  end

  assign bus.rf_we_md = we;
  assign bus.rf_rd_md = we ? wr_rd : 5'd0;
  assign bus.rf_wd_md = we ? wr_wd : 32'd0;
  assign bus.md_start = start_q;
  assign bus.md_op    = op_q;
  assign bus.md_busy  = busy;

  assign bus.stall_decode = bus.dec_valid && busy && (
    (bus.dec_uses_rs1 && hit(bus.dec_rs1, pend_rd)) ||
    (bus.dec_uses_rs2 && hit(bus.dec_rs2, pend_rd)) ||
    (bus.dec_writes_rd && hit(bus.dec_rd, pend_rd)) ||
    bus.dec_is_md ||
    (bus.dec_writes_rd && we));

  assign accept = (state == IDLE) && bus.dec_valid
                  && bus.dec_is_md && !bus.stall_decode;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = BUSY;
      BUSY: if (done) state_nx = bus.wb_pipe_we ? HOLD : IDLE;
      HOLD: if (!bus.wb_pipe_we) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      pend_rd <= 5'd0;
      hold_rd <= 5'd0;
      hold_wd <= 32'd0;
      op_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= accept;
      if (accept) begin
        pend_rd <= bus.dec_rd;
        op_q    <= bus.dec_is_div;
        count   <= '0;
      end else if (state == BUSY && !done) begin
        count <= count + 1'b1;
      end
      if (done && bus.wb_pipe_we) begin
        hold_rd <= fin_rd;
        hold_wd <= fin_wd;
      end
    end
  end
endmodule

// File: tb/tb_md_scheduler.sv
// Random-stimulus bench for md_scheduler against a transaction-level
// model of one outstanding mul/div op and its pending write.
module tb_md_scheduler;
  localparam int MAXC = 40;

  logic clock = 1'b0;
  logic reset = 1'b1;
  md_scheduler_if bus();

  md_scheduler #(
    .MAX_CYCLES(MAXC), .MUL_EXC_CODE(1),
    .DIV_EXC_CODE(2), .TIMEOUT_CODE(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: one op in flight, or one result waiting for the port
  bit          m_out, m_wait, m_start, m_op;
  int          m_age;
  logic [4:0]  m_prd, m_hrd;
  logic [31:0] m_hwd;
  int          n_to, n_hold, n_wr;

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd5;
      2: return 5'd7;
      3: return 5'd30;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic bit haz(input logic [4:0] r);
    return (r != 0) && (r == m_prd || r == 5'd30);
  endfunction

  task automatic drive(input int rdy_pct, input int we_pct);
    reset               = ($urandom_range(0, 199) == 0);
    bus.dec_valid       = ($urandom_range(0, 99) < 70);
    bus.dec_is_md       = ($urandom_range(0, 99) < 40);
    bus.dec_is_div      = 1'($urandom_range(0, 1));
    bus.dec_rs1         = pick_reg();
    bus.dec_rs2         = pick_reg();
    bus.dec_rd          = pick_reg();
    bus.dec_uses_rs1    = 1'($urandom_range(0, 1));
    bus.dec_uses_rs2    = 1'($urandom_range(0, 1));
    bus.dec_writes_rd   = 1'($urandom_range(0, 1));
    bus.wb_pipe_we      = ($urandom_range(0, 99) < we_pct);
    bus.md_result_ready = ($urandom_range(0, 99) < rdy_pct);
    bus.md_result       = $urandom;
    bus.md_exception    = ($urandom_range(0, 99) < 20);
  endtask

  initial begin
    bit          busy, to, fin, act, accept, e_we, e_stall;
    logic [4:0]  frd, wrd;
    logic [31:0] fwd, wwd;
    int          rdy_pct, we_pct;

    drive(0, 0);
    reset = 1'b1;
    bus.dec_valid = 1'b0;
    m_out = 0; m_wait = 0; m_start = 0; m_op = 0;
    m_age = 0; m_prd = 0; m_hrd = 0; m_hwd = 0;
    n_to = 0; n_hold = 0; n_wr = 0;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_busy",  {31'd0, bus.md_busy},  32'd0);
    chk("rst_start", {31'd0, bus.md_start}, 32'd0);
    chk("rst_op",    {31'd0, bus.md_op},    32'd0);
    chk("rst_we",    {31'd0, bus.rf_we_md}, 32'd0);
    chk("rst_rd",    {27'd0, bus.rf_rd_md}, 32'd0);
    chk("rst_wd",    bus.rf_wd_md,          32'd0);

    for (int seg = 0; seg < 12; seg++) begin
      case (seg % 3)
        0: begin rdy_pct = 20; we_pct = 25; end
        1: begin rdy_pct = 0;  we_pct = 30; end
        default: begin rdy_pct = 25; we_pct = 75; end
      endcase
      for (int c = 0; c < 300; c++) begin
        @(negedge clock);
        drive(rdy_pct, we_pct);
        #1;
        busy = m_out || m_wait;
        fin = 0; to = 0; frd = 0; fwd = 0;
        if (m_out) begin
          to  = !bus.md_result_ready && (m_age == MAXC - 1);
          fin = bus.md_result_ready || to;
          if (to) begin
            frd = 30; fwd = 3;
          end else if (bus.md_exception) begin
            frd = 30; fwd = m_op ? 32'd2 : 32'd1;
          end else begin
            frd = m_prd; fwd = bus.md_result;
          end
        end
        act = (fin || m_wait) && !bus.wb_pipe_we;
        wrd = fin ? frd : m_hrd;
        wwd = fin ? fwd : m_hwd;
        e_we = act && (wrd != 0);
        e_stall = bus.dec_valid && busy && (
          (bus.dec_uses_rs1 && haz(bus.dec_rs1)) ||
          (bus.dec_uses_rs2 && haz(bus.dec_rs2)) ||
          (bus.dec_writes_rd && haz(bus.dec_rd)) ||
          bus.dec_is_md ||
          (bus.dec_writes_rd && e_we));
        accept = bus.dec_valid && bus.dec_is_md && !busy;

        chk("stall", {31'd0, bus.stall_decode}, {31'd0, e_stall});
        chk("start", {31'd0, bus.md_start}, {31'd0, m_start});
        chk("op",    {31'd0, bus.md_op},    {31'd0, m_op});
        chk("busy",  {31'd0, bus.md_busy},  {31'd0, busy});
        chk("we",    {31'd0, bus.rf_we_md}, {31'd0, e_we});
        chk("rd",    {27'd0, bus.rf_rd_md}, e_we ? {27'd0, wrd} : 32'd0);
        chk("wd",    bus.rf_wd_md,          e_we ? wwd : 32'd0);

        @(posedge clock);
        if (reset) begin
          m_out = 0; m_wait = 0; m_start = 0; m_op = 0;
          m_age = 0; m_prd = 0; m_hrd = 0; m_hwd = 0;
        end else begin
          m_start = accept;
          if (e_we) n_wr++;
          if (to) n_to++;
          if (accept) begin
            m_out = 1; m_age = 0;
            m_op = bus.dec_is_div; m_prd = bus.dec_rd;
          end else if (m_out) begin
            if (fin) begin
              m_out = 0;
              if (bus.wb_pipe_we) begin
                m_wait = 1; m_hrd = frd; m_hwd = fwd; n_hold++;
              end
            end else begin
              m_age++;
            end
          end else if (m_wait && !bus.wb_pipe_we) begin
            m_wait = 0;
          end
        end
      end
    end

    $display("info: writes=%0d timeouts=%0d holds=%0d", n_wr, n_to, n_hold);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
